// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared types and constants for the arb_mux registered selector
package arb_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_t;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder: first set req at or after start
module rr_pick #(
    parameter int  NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  start,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] probe;

    // NUM_IN is a power of two, so the SEL_W-bit add wraps exactly at NUM_IN.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        probe = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            probe = start + SEL_W'(i);
            if (!found && req[probe]) begin
                found = 1'b1;
                idx   = probe;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - NUM_IN-to-1 registered valid/ready selector, fixed or round-robin; ARB_MUX_COUNT_EN adds xfer_count
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef ARB_MUX_COUNT_EN
    ,
    output logic [XFER_CNT_W-1:0]   xfer_count
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    mode_t            mode_e;
    logic             can_load;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] cand_idx;
    logic             cand_vld;
    logic             xfer;
    logic [WIDTH-1:0] in_word [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign in_word[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign mode_e    = mode_t'(mode);
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign can_load  = !out_valid || out_ready;

    rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_rr_pick (
        .req   (in_valid),
        .start (ptr_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Candidate selection and grant; reset suppresses every grant in its cycle.
    always_comb begin
        cand_idx = sel;
        cand_vld = in_valid[sel];
        in_ready = '0;
        if (mode_e == MODE_RR) begin
            cand_idx = rr_idx;
            cand_vld = rr_found;
        end
        if (!reset && can_load) begin
            if (mode_e == MODE_RR) begin
                if (rr_found) begin
                    in_ready[rr_idx] = 1'b1;
                end
            end else begin
                in_ready[sel] = 1'b1;
            end
        end
        xfer = !reset && can_load && cand_vld;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d = in_word[cand_idx];
            src_d  = cand_idx;
            if (mode_e == MODE_RR) begin
                ptr_d = cand_idx + SEL_W'(1);
            end
        end
        case (state_q)
            ST_EMPTY: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!xfer && out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_MUX_COUNT_EN
    logic [XFER_CNT_W-1:0] cnt_q, cnt_d;

    // Counts consumer handshakes, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + XFER_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - self-checking bench for arb_mux: directed vector table, corner sequences, randomized model check
module tb_arb_mux;

    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [2:0]     sel;
    logic [W-1:0]   out_data;
    logic [2:0]     out_src;
    logic           out_valid;
    logic           out_ready;
`ifdef ARB_MUX_COUNT_EN
    logic [15:0]    xfer_count;
`endif

    always #5 clk = ~clk;

    arb_mux #(
        .WIDTH  (W),
        .NUM_IN (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .sel        (sel),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef ARB_MUX_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    typedef struct {
        logic        rst;
        logic        md;
        logic [2:0]  sl;
        logic [7:0]  iv;
        logic        ordy;
        logic [31:0] seed;
        logic [7:0]  e_rdy;
        logic        e_ov;
        logic [2:0]  e_src;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    // Reference model state
    logic        m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;
    int          m_cnt;
    logic [31:0] words [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic md, input logic [2:0] sl,
                                input logic [7:0] iv, input logic ordy, input logic [31:0] seed,
                                input logic [7:0] e_rdy, input logic e_ov, input logic [2:0] e_src,
                                input logic [31:0] e_data);
        vec_t v;
        v.rst = rst; v.md = md; v.sl = sl; v.iv = iv; v.ordy = ordy; v.seed = seed;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_src = e_src; v.e_data = e_data;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic md, input logic [2:0] sl,
                         input logic [7:0] iv, input logic ordy);
        reset     = rst;
        mode      = md;
        sel       = sl;
        in_valid  = iv;
        out_ready = ordy;
    endtask

    task automatic seed_data(input logic [31:0] seed);
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = seed ^ 32'(i);
        end
    endtask

    // Rotating search from ptr, computed with modular arithmetic; -1 when nothing is valid.
    function automatic int rr_find(input logic [7:0] iv, input int p);
        for (int k = 0; k < N; k++) begin
            if (iv[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_cand(input logic md, input logic [2:0] sl, input logic [7:0] iv);
        if (md) return rr_find(iv, m_ptr);
        return iv[sl] ? int'(sl) : -1;
    endfunction

    function automatic logic [7:0] model_ready(input logic rst, input logic md,
                                               input logic [2:0] sl, input logic [7:0] iv,
                                               input logic ordy);
        int c;
        if (rst || (m_valid && !ordy)) return 8'h00;
        if (!md) return 8'(1 << sl);
        c = rr_find(iv, m_ptr);
        return (c < 0) ? 8'h00 : 8'(1 << c);
    endfunction

    task automatic model_step(input logic rst, input logic md, input logic [2:0] sl,
                              input logic [7:0] iv, input logic ordy);
        int  c;
        logic can;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
            return;
        end
        can = !m_valid || ordy;
        c   = model_cand(md, sl, iv);
        if (m_valid && ordy && m_cnt < 65535) m_cnt++;
        if (can && c >= 0) begin
            m_valid = 1'b1;
            m_data  = words[c];
            m_src   = c;
            if (md) m_ptr = (c + 1) % N;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] r_iv;
        logic [2:0] r_sel;
        logic       r_rst, r_md, r_ordy;

        // Directed vectors: expected in_ready before the edge, registered outputs after it.
        vecs.push_back(mk(1, 0, 0, 8'hFF, 1, 32'h0, 8'h00, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 3, 8'hFF, 1, 32'hDEAD_BEEC, 8'h08, 1, 3, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 0, 5, 8'h00, 1, 32'h1111_0000, 8'h20, 0, 3, 32'hDEAD_BEEF));
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 32'hA000_0000 + 32'(k * 256),
                              8'(1 << (k % 8)), 1, 3'(k % 8),
                              (32'hA000_0000 + 32'(k * 256)) ^ 32'(k % 8)));
        end
        vecs.push_back(mk(0, 1, 0, 8'h01, 1, 32'hB000_0000, 8'h01, 1, 0, 32'hB000_0000));
        vecs.push_back(mk(0, 1, 0, 8'h81, 1, 32'hB100_0000, 8'h80, 1, 7, 32'hB100_0007));
        vecs.push_back(mk(0, 1, 0, 8'h81, 1, 32'hB200_0000, 8'h01, 1, 0, 32'hB200_0000));
        vecs.push_back(mk(0, 1, 0, 8'h81, 1, 32'hB300_0000, 8'h80, 1, 7, 32'hB300_0007));
        vecs.push_back(mk(0, 0, 2, 8'h04, 1, 32'hC000_0000, 8'h04, 1, 2, 32'hC000_0002));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 32'hC100_0000, 8'h01, 1, 0, 32'hC100_0000));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 0, 32'hD000_0000, 8'h00, 1, 0, 32'hC100_0000));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 0, 32'hD100_0000, 8'h00, 1, 0, 32'hC100_0000));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 0, 32'hD200_0000, 8'h00, 1, 0, 32'hC100_0000));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 32'hD300_0000, 8'h02, 1, 1, 32'hD300_0001));
        vecs.push_back(mk(1, 1, 0, 8'hFF, 1, 32'hE000_0000, 8'h00, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 32'hE100_0000, 8'h01, 1, 0, 32'hE100_0000));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 32'hE200_0000, 8'h00, 1, 0, 32'hE100_0000));
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 32'hE300_0000, 8'h00, 0, 0, 32'hE100_0000));
        vecs.push_back(mk(0, 1, 0, 8'h04, 0, 32'hE400_0000, 8'h04, 1, 2, 32'hE400_0002));
        vecs.push_back(mk(0, 0, 6, 8'hFF, 0, 32'hE500_0000, 8'h00, 1, 2, 32'hE400_0002));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].md, vecs[i].sl, vecs[i].iv, vecs[i].ordy);
            seed_data(vecs[i].seed);
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(vecs[i].e_src));
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
        end

        // Handshake count over a fixed-mode burst, then reset in the middle of it.
        drive(1, 0, 0, 8'h01, 1);
        seed_data(32'h5500_0000);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 8'h01, 1);
            @(posedge clk); #1;
        end
        check("burst_out_valid", 32'(out_valid), 32'd1);
`ifdef ARB_MUX_COUNT_EN
        check("burst_xfer_count", 32'(xfer_count), 32'd5);
`endif
        drive(1, 0, 0, 8'h01, 1);
        @(negedge clk);
        check("midreset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_data", out_data, 32'd0);
`ifdef ARB_MUX_COUNT_EN
        check("midreset_xfer_count", 32'(xfer_count), 32'd0);
`endif

        // Randomized traffic against the reference model, starting from reset.
        model_step(1, 0, 0, 8'h00, 0);
        for (int n = 0; n < 3000; n++) begin
            r_rst  = (n == 0) || ($urandom_range(0, 63) == 0);
            r_md   = 1'($urandom_range(0, 1));
            r_sel  = 3'($urandom_range(0, 7));
            r_iv   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom & $urandom);
            r_ordy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                words[i] = $urandom;
                in_data[i*W +: W] = words[i];
            end
            drive(r_rst, r_md, r_sel, r_iv, r_ordy);
            @(negedge clk);
            check("rand_in_ready", 32'(in_ready),
                  32'(model_ready(r_rst, r_md, r_sel, r_iv, r_ordy)));
            check("rand_onehot", 32'($countones(in_ready) <= 1), 32'd1);
            model_step(r_rst, r_md, r_sel, r_iv, r_ordy);
            @(posedge clk);
            #1;
            check("rand_out_valid", 32'(out_valid), 32'(m_valid));
            check("rand_out_src", 32'(out_src), 32'(m_src));
            check("rand_out_data", out_data, m_data);
`ifdef ARB_MUX_COUNT_EN
            check("rand_xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised WIDTH-bit, NUM_IN-to-1 registered selector with valid/ready handshaking on every input and on the output. It operates in one of two modes: fixed-select, where a `sel` port chooses the source, or round-robin, where a rotating pointer arbitrates among valid sources. The block sits between datapath producers (register-file read ports, forwarding sources) and a single consumer. It replaces single-bit combinational select trees wherever a multi-bit, flow-controlled, one-cycle-registered choice is needed.

## Interface
- WIDTH, 32, data bits per input and output
- NUM_IN, 8, number of sources; power of two, 2..32
- SEL_W, $clog2(NUM_IN), localparam, select/index width
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- in_data  input  NUM_IN*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  source i has data
- in_ready  output  NUM_IN  source i is accepted this cycle
- mode  input  1  0 = fixed-select, 1 = round-robin
- sel  input  SEL_W  source index used in fixed mode; ignored in round-robin mode
- out_data  output  WIDTH  registered data
- out_src  output  SEL_W  index of the source that produced out_data
- out_valid  output  1  output register full
- out_ready  input  1  consumer accepts out_data

## Operation
- Output stage is one register. State is EMPTY (out_valid=0) or FULL (out_valid=1).
- can_load = !out_valid | out_ready.
- Fixed mode:
  - Candidate is `sel`.
  - in_ready[sel] = can_load. All other in_ready bits are 0.
  - Transfer occurs when in_valid[sel] & can_load.
- Round-robin mode:
  - Candidate is the first i with in_valid[i] set, scanning ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1 (wrap-around).
  - in_ready is asserted only at the candidate, and only if can_load.
  - When no input is valid, in_ready is all 0.
- On a transfer:
  - out_data <= selected in_data; out_src <= selected index; out_valid <= 1.
  - In round-robin mode, ptr <= (index+1) mod NUM_IN.
- Output drains without a refill (out_valid & out_ready with no transfer): out_valid <= 0. out_data and out_src hold their values.
- Simultaneous drain and load: the register is replaced and out_valid stays 1 (full throughput).
- ptr changes only on round-robin transfers. It holds its value through fixed mode.
- `mode` and `sel` are sampled combinationally each cycle. A change takes effect in the same cycle, with no flush.
- At most one in_ready bit is high in any cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is all 0 during the reset cycle.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N.
- Throughput: one transfer per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 forces in_ready to all 0. out_data is stable until accepted.
- Reset asserted mid-transfer: reset dominates. Pending data is discarded and ptr returns to 0.
- All paths from in_valid/out_ready to in_ready are combinational. No path exists from in_* to out_* except through the register.

## Configuration
- Macro ARB_MUX_COUNT_EN.
- Defined:
  - Adds output port xfer_count [15:0].
  - Increments on every output handshake (out_valid & out_ready).
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package arb_mux_pkg holds:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mode_t
  - typedef enum logic {ST_EMPTY, ST_FULL} state_t
  - constant XFER_CNT_W = 16
- One sub-module, rr_pick: purely combinational rotating priority encoder, parameterised by NUM_IN.
  - Inputs: req[NUM_IN], start[SEL_W].
  - Outputs: found, idx[SEL_W].
- arb_mux contains: the output register, ptr, the mode/select logic, and the optional counter.

## Test plan
- Reset then idle, NUM_IN=8, WIDTH=32 -> out_valid=0, out_data=0, out_src=0, in_ready=8'h00.
- Fixed mode, sel=3, in_valid=8'hFF, in_data[3]=32'hDEAD_BEEF, out_ready=1 -> in_ready=8'h08; next cycle out_data=32'hDEAD_BEEF, out_src=3.
- Round-robin mode, in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_src sequence 0,1,2,…,7,0,1.
- Round-robin mode, in_valid=8'h81, ptr=1 -> grant 7, then 0, then 7 (wrap-around).
- out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_data stable; out_ready=1 with a source valid -> drain and load occur in the same cycle, out_valid stays 1.
- ARB_MUX_COUNT_EN defined: 5 handshakes -> xfer_count=5; reset asserted mid-burst -> xfer_count=0, out_valid=0 next cycle.
